div_share_arb: RTL and testbench
================================

# div_share_arb

Shared-divider scheduler for the QR MIMO detector back end. It arbitrates NREQ requesters, such as per-row back-substitution and normalisation units, onto one signed 56-bit combinational divider instance. It registers the selected operands, holds them stable for a configured multicycle window, captures the quotient, and returns it to the winning requester with a valid/ready handshake.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 56, operand/quotient width, two's complement
- DIV_LAT, 3, cycles the divider inputs are held before the quotient is sampled (≥1)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester operation request
- req_ready  out  NREQ  one-hot grant; transfer on req_valid[i] && req_ready[i]
- req_num  in  NREQ*W  dividends, requester i at [i*W +: W]
- req_den  in  NREQ*W  divisors, same packing
- div_a  out  W  registered dividend to the divider
- div_b  out  W  registered divisor to the divider
- div_q  in  W  divider quotient (combinational from div_a/div_b)
- resp_valid  out  1  quotient available
- resp_ready  in  1  consumer accepts response
- resp_id  out  $clog2(NREQ)  index of the requester that owns resp_quot
- resp_quot  out  W  registered quotient
- busy  out  1  high in any state other than IDLE

## Operation
- FSM has three states: IDLE, WAIT, RESP.
- IDLE:
  - If any req_valid is high, pick a winner round-robin, starting at last_id+1 modulo NREQ.
  - Drive req_ready[winner]=1 combinationally. All other req_ready bits are 0.
  - On the clock edge, latch div_a/div_b from the winner's slice, resp_id=winner, last_id=winner, cnt=DIV_LAT-1, then go to WAIT.
  - If no req_valid is high, stay in IDLE and keep req_ready=0.
- WAIT:
  - div_a/div_b stay frozen.
  - If cnt≠0, decrement it.
  - If cnt==0, register resp_quot=div_q and go to RESP.
  - req_ready is 0 throughout WAIT.
- RESP:
  - resp_valid=1.
  - resp_quot and resp_id stay stable until resp_ready.
  - On resp_valid && resp_ready, go to IDLE.
  - No new grant is issued in the same cycle.
- The block does not alter arithmetic. resp_quot is exactly div_q, i.e. truncation toward zero, and 0 when either operand is 0. Zero divisors are passed through unchanged.
- A requester that drops req_valid before its grant loses nothing; it is simply not selected.

## Timing
- Reset values:
  - state=IDLE, req_ready=0, div_a=0, div_b=0, resp_valid=0, resp_quot=0, resp_id=0, busy=0.
  - last_id=NREQ-1, so requester 0 wins first.
- Accept edge E0. Quotient is sampled at edge E0+DIV_LAT. resp_valid is high in the cycle after that edge.
- Minimum issue interval is DIV_LAT+2 cycles with resp_ready tied high: 1 IDLE + DIV_LAT WAIT + 1 RESP.
- Simultaneous requests: exactly one grant per IDLE cycle. A requester that is continuously valid is granted within NREQ operations.
- resp_ready high while resp_valid is low is ignored.
- Reset asserted mid-operation:
  - All outputs return to their reset values immediately, asynchronously.
  - The in-flight operation is discarded and no response is produced.
  - After rst_n rises, the first grant goes to requester 0.

## Configuration
- DIV_ARB_FIXED_PRI_EN:
  - When defined, arbitration is fixed priority: the lowest index wins and last_id is unused.
  - When undefined (the default), arbitration is round-robin as specified above.
- The FSM, latency and handshake are identical in both builds.

## Test plan
- Single request: req_valid[2]=1, num=100, den=-7, DIV_LAT=3, bench divider model. Required response: req_ready[2] for 1 cycle, resp_valid 4 cycles after accept, resp_quot=-14, resp_id=2.
- All four requesters valid continuously, resp_ready=1. Required response: grants in order 0,1,2,3,0 at 5-cycle spacing. With DIV_ARB_FIXED_PRI_EN defined, every grant goes to 0.
- Backpressure: resp_ready=0 for 10 cycles during RESP. Required response: resp_quot/resp_id held, req_ready stays 0, one response only after resp_ready=1.
- Zero operands: num=0, den=5 gives 0; num=9, den=0 gives resp_quot=div_q, i.e. 0. No hang, and the FSM returns to IDLE.
- Async reset in WAIT with cnt=1. Required response: resp_valid stays 0, div_a=div_b=0 immediately. After release, a req_valid on requesters 1 and 0 grants 0 first.
- Operand stability: toggle req_num[0] during WAIT. Required response: div_a unchanged and resp_quot equal to the quotient of the originally latched operands.

Source files
------------

// File: rtl/div_share_arb.sv
// Shared-divider scheduler: arbitrates NREQ requesters onto one combinational divider,
// holds operands for DIV_LAT cycles, returns quotient. Define DIV_ARB_FIXED_PRI_EN for fixed priority.
module div_share_arb #(
  parameter int NREQ    = 4,
  parameter int W       = 56,
  parameter int DIV_LAT = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*W-1:0]        req_num,
  input  logic [NREQ*W-1:0]        req_den,
  output logic [W-1:0]             div_a,
  output logic [W-1:0]             div_b,
  input  logic [W-1:0]             div_q,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [$clog2(NREQ)-1:0]  resp_id,
  output logic [W-1:0]             resp_quot,
  output logic                     busy
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, quot_q, quot_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [IDW-1:0]  win;
  logic [NREQ-1:0] grant;

`ifdef DIV_ARB_FIXED_PRI_EN
  always_comb begin
    win = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[k]) win = IDW'(k);
    end
  end
`else
  logic [IDW-1:0] last_id_q, last_id_d;
  logic           found;

  // Search starts one past the previous winner so every requester gets a turn.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && req_valid[(int'(last_id_q) + k) % NREQ]) begin
        win   = IDW'((int'(last_id_q) + k) % NREQ);
        found = 1'b1;
      end
    end
  end
`endif

  // NOTE: every signal driven here gets a default first, otherwise a latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    quot_d  = quot_q;
    id_d    = id_q;
    grant   = '0;
`ifndef DIV_ARB_FIXED_PRI_EN
    last_id_d = last_id_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (|req_valid) begin
          grant[win] = 1'b1;
          a_d        = req_num[int'(win)*W +: W];
          b_d        = req_den[int'(win)*W +: W];
          id_d       = win;
          cnt_d      = CW'(DIV_LAT - 1);
          state_d    = S_WAIT;
`ifndef DIV_ARB_FIXED_PRI_EN
          last_id_d  = win;
`endif
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          quot_d  = div_q;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      quot_q    <= '0;
      id_q      <= '0;
`ifndef DIV_ARB_FIXED_PRI_EN
      last_id_q <= IDW'(NREQ - 1);
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      quot_q    <= quot_d;
      id_q      <= id_d;
`ifndef DIV_ARB_FIXED_PRI_EN
      last_id_q <= last_id_d;
`endif
    end
  end

  assign req_ready  = grant;
  assign div_a      = a_q;
  assign div_b      = b_q;
  assign resp_quot  = quot_q;
  assign resp_id    = id_q;
  assign resp_valid = (state_q == S_RESP);
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_div_share_arb.sv
// Directed bench for div_share_arb: table of single operations plus arbitration,
// backpressure, mid-operation reset and operand-stability sequences.
module tb_div_share_arb;

  localparam int NREQ    = 4;
  localparam int W       = 56;
  localparam int DIV_LAT = 3;
  localparam int IDW     = $clog2(NREQ);

  logic                clk;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*W-1:0]   req_num;
  logic [NREQ*W-1:0]   req_den;
  logic [W-1:0]        div_a;
  logic [W-1:0]        div_b;
  logic [W-1:0]        div_q;
  logic                resp_valid;
  logic                resp_ready;
  logic [IDW-1:0]      resp_id;
  logic [W-1:0]        resp_quot;
  logic                busy;

  int passed = 0;
  int total  = 0;

  div_share_arb #(.NREQ(NREQ), .W(W), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_num(req_num), .req_den(req_den),
    .div_a(div_a), .div_b(div_b), .div_q(div_q),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_quot(resp_quot), .busy(busy)
  );

  // Divider model: truncating signed division, zero divisor yields 0.
  assign div_q = (div_b == '0) ? '0 : W'($signed(div_a) / $signed(div_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int             id;
    logic [W-1:0]   num;
    logic [W-1:0]   den;
    logic [W-1:0]   quot;
  } vec_t;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic set_op(input int id, input logic [W-1:0] num, input logic [W-1:0] den);
    req_num[id*W +: W] = num;
    req_den[id*W +: W] = den;
  endtask

  task automatic wait_grant(output int cyc);
    cyc = 0;
    @(negedge clk);
    while (req_ready == '0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic wait_resp(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!resp_valid && cyc < 30);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("drain_idle", W'(busy), 0);
  endtask

  // One isolated operation with resp_ready held high.
  task automatic run_op(input string tag, input vec_t v);
    int n;
    @(posedge clk); #1;
    set_op(v.id, v.num, v.den);
    req_valid[v.id] = 1'b1;
    wait_grant(n);
    check({tag, "_grant"}, W'(req_ready), W'(1 << v.id));
    @(posedge clk); #1;
    req_valid[v.id] = 1'b0;
    wait_resp(n);
    check({tag, "_latency"}, W'(n), W'(DIV_LAT + 1));
    check({tag, "_div_a"}, div_a, v.num);
    check({tag, "_quot"}, resp_quot, v.quot);
    check({tag, "_id"}, W'(resp_id), W'(v.id));
    @(negedge clk);
    check({tag, "_idle"}, W'(busy), 0);
  endtask

  vec_t vecs[6];
  int   g_id[5];
  int   g_cyc[5];
  int   ng;
  int   n;
  int   resp_cnt;

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    req_num    = '0;
    req_den    = '0;
    resp_ready = 1'b1;

    vecs[0] = '{2, W'(100),   W'(-7),   W'(-14)};
    vecs[1] = '{0, W'(0),     W'(5),    W'(0)};
    vecs[2] = '{1, W'(9),     W'(0),    W'(0)};
    vecs[3] = '{3, W'(-100),  W'(7),    W'(-14)};
    vecs[4] = '{0, W'(-1000), W'(-33),  W'(30)};
    vecs[5] = '{3, W'(56'd1125899906842624), W'(3), W'(56'd375299968947541)};

    #12;
    check("rst_req_ready", W'(req_ready), 0);
    check("rst_div_a", div_a, 0);
    check("rst_div_b", div_b, 0);
    check("rst_resp_valid", W'(resp_valid), 0);
    check("rst_resp_quot", resp_quot, 0);
    check("rst_resp_id", W'(resp_id), 0);
    check("rst_busy", W'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_op($sformatf("vec%0d", i), vecs[i]);

    // Arbitration with all requesters continuously valid, starting from reset.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) set_op(i, W'(10 * (i + 1)), W'(2));
    @(posedge clk); #1;
    req_valid = '1;
    ng = 0;
    for (int c = 0; c < 60 && ng < 5; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        for (int k = 0; k < NREQ; k++) if (req_ready[k]) g_id[ng] = k;
        g_cyc[ng] = c;
        ng++;
        if (ng == 5) begin
          @(posedge clk); #1;
          req_valid = '0;
        end
      end
    end
    check("rr_grant_count", W'(ng), 5);
    for (int i = 0; i < 5; i++) begin
`ifdef DIV_ARB_FIXED_PRI_EN
      check($sformatf("rr_grant%0d_id", i), W'(g_id[i]), 0);
`else
      check($sformatf("rr_grant%0d_id", i), W'(g_id[i]), W'(i % NREQ));
`endif
      if (i > 0) check($sformatf("rr_spacing%0d", i), W'(g_cyc[i] - g_cyc[i-1]), W'(DIV_LAT + 2));
    end
    req_valid = '0;
    @(negedge clk);
    wait_idle();

    // Backpressure: response held for 10 cycles while another requester waits.
    resp_ready = 1'b0;
    @(posedge clk); #1;
    set_op(1, W'(50), W'(5));
    req_valid[1] = 1'b1;
    wait_grant(n);
    check("bp_grant", W'(req_ready), W'(4'b0010));
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    set_op(3, W'(8), W'(2));
    req_valid[3] = 1'b1;
    wait_resp(n);
    check("bp_latency", W'(n), W'(DIV_LAT + 1));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d_valid", i), W'(resp_valid), 1);
      check($sformatf("bp_hold%0d_quot", i), resp_quot, W'(10));
      check($sformatf("bp_hold%0d_id", i), W'(resp_id), 1);
      check($sformatf("bp_hold%0d_ready", i), W'(req_ready), 0);
    end
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    resp_ready   = 1'b1;
    resp_cnt     = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (resp_valid) resp_cnt++;
    end
    check("bp_single_resp", W'(resp_cnt), 1);
    check("bp_idle", W'(busy), 0);

    // Asynchronous reset while in WAIT with cnt==1.
    @(posedge clk); #1;
    set_op(2, W'(100), W'(3));
    req_valid[2] = 1'b1;
    wait_grant(n);
    check("rstw_grant", W'(req_ready), W'(4'b0100));
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rstw_pre_div_a", div_a, W'(100));
    rst_n = 1'b0;
    #1;
    check("rstw_div_a", div_a, 0);
    check("rstw_div_b", div_b, 0);
    check("rstw_resp_valid", W'(resp_valid), 0);
    check("rstw_busy", W'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    resp_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (resp_valid) resp_cnt++;
    end
    check("rstw_no_resp", W'(resp_cnt), 0);
    @(posedge clk); #1;
    set_op(0, W'(40), W'(8));
    set_op(1, W'(7), W'(7));
    req_valid[1:0] = 2'b11;
    wait_grant(n);
    check("rstw_first_grant", W'(req_ready), W'(4'b0001));
    @(posedge clk); #1;
    req_valid = '0;
    wait_resp(n);
    check("rstw_quot", resp_quot, W'(5));
    check("rstw_id", W'(resp_id), 0);
    @(negedge clk);
    wait_idle();

    // Operand stability: requester 0 changes its operands during WAIT.
    @(posedge clk); #1;
    set_op(0, W'(81), W'(9));
    req_valid[0] = 1'b1;
    wait_grant(n);
    check("stab_grant", W'(req_ready), W'(4'b0001));
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    for (int i = 0; i < DIV_LAT; i++) begin
      set_op(0, W'(999 + i), W'(1));
      @(negedge clk);
      check($sformatf("stab_div_a%0d", i), div_a, W'(81));
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("stab_valid", W'(resp_valid), 1);
    check("stab_quot", resp_quot, W'(9));
    @(negedge clk);
    wait_idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
